// File: rtl/spdr_pkg.sv
// Shared constants and helpers for the buffered SPI data register.
// Imported by the FIFO sub-module, the interface and the top level.
package spdr_pkg;

  localparam int SPDR_DATA_W = 8;

  // RX-full policy selectors.
  localparam int RX_DROP_NEW = 0;
  localparam int RX_DROP_OLD = 1;

  // Occupancy counters must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/spdr_if.sv
// User/shift-engine bus of spdr_fifo, grouped so benches can bind to one handle.
// Strobes are single-cycle qualifiers sampled on the rising clock edge.
interface spdr_if
  import spdr_pkg::*;
#(
  parameter int DATA_W = SPDR_DATA_W,
  parameter int DEPTH  = 4,
  localparam int CNT_W = cnt_w(DEPTH)
);

  // Handshake: every strobe (wr_en, tx_pop, rx_push, rd_en, flag_clr) is a
  // one-cycle request with no ready back-pressure; a request the FIFO cannot
  // honour is either ignored (pop on empty) or flagged (push on full).
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              tx_pop;
  logic [DATA_W-1:0] tx_data;
  logic              tx_empty;
  logic              tx_full;
  logic [CNT_W-1:0]  tx_count;

  logic              rx_push;
  logic [DATA_W-1:0] rx_wdata;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rx_empty;
  logic              rx_full;
  logic [CNT_W-1:0]  rx_count;

  logic              wcol;
  logic              ovr;
  logic              flag_clr;

  modport slave (
    input  wr_en, wr_data, tx_pop, rx_push, rx_wdata, rd_en, flag_clr,
    output tx_data, tx_empty, tx_full, tx_count,
    output rd_data, rx_empty, rx_full, rx_count, wcol, ovr
  );

  modport master (
    output wr_en, wr_data, tx_pop, rx_push, rx_wdata, rd_en, flag_clr,
    input  tx_data, tx_empty, tx_full, tx_count,
    input  rd_data, rx_empty, rx_full, rx_count, wcol, ovr
  );

endinterface

// File: rtl/spdr_sync_fifo.sv
// Synchronous show-ahead FIFO with separate occupancy count and an optional
// overwrite-oldest mode; overflow pulses whenever a push meets a full FIFO.
module spdr_sync_fifo
  import spdr_pkg::*;
#(
  parameter int DATA_W    = SPDR_DATA_W,
  parameter int DEPTH     = 4,
  parameter int OVERWRITE = 0,
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int CNT_W    = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              pop_ok, push_ok, ovw;

  always_comb begin
    pop_ok   = pop && !empty_q;
    push_ok  = push && (!full_q || pop_ok);
    // Overwrite replaces the oldest entry: both pointers advance, count holds.
    ovw      = push && full_q && !pop && (OVERWRITE != 0);
    overflow = push && full_q && !pop;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok || ovw) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok || ovw)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  // Storage is deliberately unreset; the empty gate on head hides stale words.
  always_ff @(posedge clk) begin
    if (push_ok || ovw) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = empty_q ? '0 : mem_q[rd_ptr_q];
  assign empty = empty_q;
  assign full  = full_q;
  assign count = count_q;

endmodule

// File: rtl/spdr_fifo.sv
// Buffered SPI data register: TX and RX FIFOs between user and shift engine,
// plus sticky write-collision and receive-overrun flags.
module spdr_fifo
  import spdr_pkg::*;
#(
  parameter int DATA_W       = SPDR_DATA_W,
  parameter int DEPTH        = 4,
  parameter int RX_OVERWRITE = RX_DROP_NEW
) (
  input logic  clk,
  input logic  rst,
  spdr_if.slave bus
);

  logic tx_ovf, rx_ovf;
  logic wcol_q, wcol_d;
  logic ovr_q, ovr_d;

  spdr_sync_fifo #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .OVERWRITE(0)
  ) u_tx_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .push     (bus.wr_en),
    .push_data(bus.wr_data),
    .pop      (bus.tx_pop),
    .head     (bus.tx_data),
    .empty    (bus.tx_empty),
    .full     (bus.tx_full),
    .count    (bus.tx_count),
    .overflow (tx_ovf)
  );

  spdr_sync_fifo #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .OVERWRITE(RX_OVERWRITE)
  ) u_rx_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .push     (bus.rx_push),
    .push_data(bus.rx_wdata),
    .pop      (bus.rd_en),
    .head     (bus.rd_data),
    .empty    (bus.rx_empty),
    .full     (bus.rx_full),
    .count    (bus.rx_count),
    .overflow (rx_ovf)
  );

  // A set event in the clearing cycle wins over flag_clr.
  always_comb begin
    wcol_d = tx_ovf | (wcol_q & ~bus.flag_clr);
    ovr_d  = rx_ovf | (ovr_q & ~bus.flag_clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcol_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      wcol_q <= wcol_d;
      ovr_q  <= ovr_d;
    end
  end

  assign bus.wcol = wcol_q;
  assign bus.ovr  = ovr_q;

endmodule

// File: tb/tb_spdr_fifo.sv
// Bench for spdr_fifo: two instances (drop-new and drop-old RX policy) share
// one stimulus stream and are compared against queue-based models each cycle.
module tb_spdr_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic clk;
  logic rst;

  spdr_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) if_new ();
  spdr_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) if_old ();

  spdr_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RX_OVERWRITE(0)) u_dut_new (
    .clk(clk), .rst(rst), .bus(if_new)
  );

  spdr_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RX_OVERWRITE(1)) u_dut_old (
    .clk(clk), .rst(rst), .bus(if_old)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [DATA_W-1:0] tx_exp_q[$];
  logic [DATA_W-1:0] rxn_exp_q[$];
  logic [DATA_W-1:0] rxo_exp_q[$];
  logic wcol_m;
  logic ovr_m;
  int   tests_run;
  int   tests_failed;

  task automatic chk(input string tag, input string what,
                     input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s/%s: observed %0h expected %0h", tag, what, obs, exp);
    end
  endtask

  task automatic model_reset();
    tx_exp_q.delete();
    rxn_exp_q.delete();
    rxo_exp_q.delete();
    wcol_m = 1'b0;
    ovr_m  = 1'b0;
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic w, input logic [DATA_W-1:0] wd, input logic tp,
                       input logic rp, input logic [DATA_W-1:0] rwd, input logic re,
                       input logic fc);
    if_new.wr_en = w;  if_new.wr_data = wd; if_new.tx_pop = tp;
    if_new.rx_push = rp; if_new.rx_wdata = rwd; if_new.rd_en = re; if_new.flag_clr = fc;
    if_old.wr_en = w;  if_old.wr_data = wd; if_old.tx_pop = tp;
    if_old.rx_push = rp; if_old.rx_wdata = rwd; if_old.rd_en = re; if_old.flag_clr = fc;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // Reference model: one clock of FIFO semantics expressed on queues.
  task automatic model_step(input logic w, input logic [DATA_W-1:0] wd, input logic tp,
                            input logic rp, input logic [DATA_W-1:0] rwd, input logic re,
                            input logic fc);
    bit tx_was_full;
    bit rx_was_full;
    bit wset;
    bit oset;
    logic [DATA_W-1:0] junk;
    tx_was_full = (tx_exp_q.size() == DEPTH);
    rx_was_full = (rxn_exp_q.size() == DEPTH);
    wset = 0;
    oset = 0;
    if (tp && tx_exp_q.size() > 0) junk = tx_exp_q.pop_front();
    if (w) begin
      if (!tx_was_full || tp) tx_exp_q.push_back(wd);
      else wset = 1;
    end
    if (re && rxn_exp_q.size() > 0) begin
      junk = rxn_exp_q.pop_front();
      junk = rxo_exp_q.pop_front();
    end
    if (rp) begin
      if (!rx_was_full || re) begin
        rxn_exp_q.push_back(rwd);
        rxo_exp_q.push_back(rwd);
      end else begin
        oset = 1;
        junk = rxo_exp_q.pop_front();
        rxo_exp_q.push_back(rwd);
      end
    end
    wcol_m = wset | (wcol_m & ~fc);
    ovr_m  = oset | (ovr_m & ~fc);
  endtask

  task automatic check_all(input string tag);
    logic [DATA_W-1:0] tx_h, rn_h, ro_h;
    tx_h = (tx_exp_q.size() == 0) ? '0 : tx_exp_q[0];
    rn_h = (rxn_exp_q.size() == 0) ? '0 : rxn_exp_q[0];
    ro_h = (rxo_exp_q.size() == 0) ? '0 : rxo_exp_q[0];
    chk(tag, "new.tx_data",  32'(if_new.tx_data),  32'(tx_h));
    chk(tag, "new.tx_count", 32'(if_new.tx_count), 32'(tx_exp_q.size()));
    chk(tag, "new.tx_empty", 32'(if_new.tx_empty), 32'(tx_exp_q.size() == 0));
    chk(tag, "new.tx_full",  32'(if_new.tx_full),  32'(tx_exp_q.size() == DEPTH));
    chk(tag, "new.rd_data",  32'(if_new.rd_data),  32'(rn_h));
    chk(tag, "new.rx_count", 32'(if_new.rx_count), 32'(rxn_exp_q.size()));
    chk(tag, "new.rx_empty", 32'(if_new.rx_empty), 32'(rxn_exp_q.size() == 0));
    chk(tag, "new.rx_full",  32'(if_new.rx_full),  32'(rxn_exp_q.size() == DEPTH));
    chk(tag, "new.wcol",     32'(if_new.wcol),     32'(wcol_m));
    chk(tag, "new.ovr",      32'(if_new.ovr),      32'(ovr_m));
    chk(tag, "old.tx_data",  32'(if_old.tx_data),  32'(tx_h));
    chk(tag, "old.tx_count", 32'(if_old.tx_count), 32'(tx_exp_q.size()));
    chk(tag, "old.rd_data",  32'(if_old.rd_data),  32'(ro_h));
    chk(tag, "old.rx_count", 32'(if_old.rx_count), 32'(rxo_exp_q.size()));
    chk(tag, "old.rx_empty", 32'(if_old.rx_empty), 32'(rxo_exp_q.size() == 0));
    chk(tag, "old.rx_full",  32'(if_old.rx_full),  32'(rxo_exp_q.size() == DEPTH));
    chk(tag, "old.wcol",     32'(if_old.wcol),     32'(wcol_m));
    chk(tag, "old.ovr",      32'(if_old.ovr),      32'(ovr_m));
    chk(tag, "new.tx_bound", 32'(if_new.tx_count <= DEPTH), 32'd1);
    chk(tag, "new.rx_bound", 32'(if_new.rx_count <= DEPTH), 32'd1);
    chk(tag, "old.rx_bound", 32'(if_old.rx_count <= DEPTH), 32'd1);
  endtask

  // One cycle: drive at negedge, model on posedge, check at next negedge.
  task automatic step(input string tag, input logic w, input logic [DATA_W-1:0] wd,
                      input logic tp, input logic rp, input logic [DATA_W-1:0] rwd,
                      input logic re, input logic fc);
    drive(w, wd, tp, rp, rwd, re, fc);
    @(posedge clk);
    model_step(w, wd, tp, rp, rwd, re, fc);
    @(negedge clk);
    idle();
    check_all(tag);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [DATA_W-1:0] tx_heads [4];
    logic [DATA_W-1:0] rxn_reads [4];
    logic [DATA_W-1:0] rxo_reads [4];
    tx_heads  = '{8'h22, 8'h33, 8'h44, 8'h66};
    rxn_reads = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    rxo_reads = '{8'hA2, 8'hA3, 8'hA4, 8'hA5};
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b0;
    idle();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all("reset");
    chk("reset", "tx_empty_const", 32'(if_new.tx_empty), 32'd1);
    rst = 1'b1;

    // Fill TX, then collide.
    step("fill1", 1, 8'h11, 0, 0, '0, 0, 0);
    chk("fill1", "tx_count_const", 32'(if_new.tx_count), 32'd1);
    step("fill2", 1, 8'h22, 0, 0, '0, 0, 0);
    step("fill3", 1, 8'h33, 0, 0, '0, 0, 0);
    step("fill4", 1, 8'h44, 0, 0, '0, 0, 0);
    chk("fill4", "tx_full_const", 32'(if_new.tx_full), 32'd1);
    chk("fill4", "tx_data_const", 32'(if_new.tx_data), 32'h11);
    step("wcol", 1, 8'h55, 0, 0, '0, 0, 0);
    chk("wcol", "wcol_const", 32'(if_new.wcol), 32'd1);
    chk("wcol", "tx_count_const", 32'(if_new.tx_count), 32'd4);
    chk("wcol", "tx_data_const", 32'(if_new.tx_data), 32'h11);

    // Write and pop together while full.
    step("wr_pop_full", 1, 8'h66, 1, 0, '0, 0, 0);
    chk("wr_pop_full", "tx_count_const", 32'(if_new.tx_count), 32'd4);
    chk("wr_pop_full", "tx_data_const", 32'(if_new.tx_data), 32'h22);
    for (int i = 0; i < 4; i++) begin
      chk("drain", "tx_head_const", 32'(if_new.tx_data), 32'(tx_heads[i]));
      step("drain", 0, '0, 1, 0, '0, 0, 0);
    end
    chk("drain", "tx_empty_const", 32'(if_new.tx_empty), 32'd1);
    chk("drain", "tx_data_zero", 32'(if_new.tx_data), 32'd0);

    // Flag clear alone.
    step("clr", 0, '0, 0, 0, '0, 0, 1);
    chk("clr", "wcol_const", 32'(if_new.wcol), 32'd0);

    // RX overflow under both policies.
    for (int i = 0; i < 5; i++)
      step("rx_fill", 0, '0, 0, 1, 8'(8'hA1 + i), 0, 0);
    chk("rx_ovf", "new.ovr_const", 32'(if_new.ovr), 32'd1);
    chk("rx_ovf", "old.ovr_const", 32'(if_old.ovr), 32'd1);
    chk("rx_ovf", "new.rx_count_const", 32'(if_new.rx_count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("rx_read", "new.rd_data_const", 32'(if_new.rd_data), 32'(rxn_reads[i]));
      chk("rx_read", "old.rd_data_const", 32'(if_old.rd_data), 32'(rxo_reads[i]));
      step("rx_read", 0, '0, 0, 0, '0, 1, 0);
    end

    // Clear racing a fresh overflow: the set must win.
    step("clr2", 0, '0, 0, 0, '0, 0, 1);
    chk("clr2", "ovr_const", 32'(if_new.ovr), 32'd0);
    for (int i = 0; i < 4; i++)
      step("rx_fill2", 0, '0, 0, 1, 8'(8'hB0 + i), 0, 0);
    step("clr_race", 0, '0, 0, 1, 8'hBF, 0, 1);
    chk("clr_race", "ovr_const", 32'(if_new.ovr), 32'd1);
    step("clr3", 0, '0, 0, 0, '0, 0, 1);
    for (int i = 0; i < 4; i++)
      step("rx_drain", 0, '0, 0, 0, '0, 1, 0);

    // Read from empty RX.
    step("rd_empty", 0, '0, 0, 0, '0, 1, 0);
    chk("rd_empty", "rx_count_const", 32'(if_new.rx_count), 32'd0);
    chk("rd_empty", "ovr_const", 32'(if_new.ovr), 32'd0);

    // Mid-cycle asynchronous reset with queued TX words.
    for (int i = 0; i < 3; i++)
      step("pre_rst", 1, 8'(8'hC0 + i), 0, 1, 8'(8'hD0 + i), 0, 0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("mid_rst", "tx_count_const", 32'(if_new.tx_count), 32'd0);
    chk("mid_rst", "tx_empty_const", 32'(if_new.tx_empty), 32'd1);
    chk("mid_rst", "tx_data_zero", 32'(if_new.tx_data), 32'd0);
    chk("mid_rst", "rx_count_const", 32'(if_old.rx_count), 32'd0);
    @(negedge clk);
    check_all("mid_rst");
    rst = 1'b1;

    // Random traffic, biased toward filling then draining.
    for (int i = 0; i < 400; i++) begin
      int fill_bias;
      fill_bias = ((i / 50) % 2 == 0) ? 70 : 30;
      step("rand",
           $urandom_range(0, 99) < fill_bias, 8'($urandom),
           $urandom_range(0, 99) >= fill_bias,
           $urandom_range(0, 99) < fill_bias, 8'($urandom),
           $urandom_range(0, 99) >= fill_bias,
           $urandom_range(0, 99) < 8);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
